// File: rtl/pll_phase_stepper_if.sv
// Command-side interface of pll_phase_stepper: request fields in, status and tracker readback out.
interface pll_phase_stepper_if #(
    parameter int PHASE_W = 8
);
    logic               update;
    logic [2:0]         sel;
    logic [PHASE_W-1:0] target_phase;
    logic               pll_clksrc;
    logic               force_areset;
    logic               busy;
    logic               error;
    logic [PHASE_W-1:0] cur_phase;

    modport master (
        output update, sel, target_phase, pll_clksrc, force_areset,
        input  busy, error, cur_phase
    );

    modport slave (
        input  update, sel, target_phase, pll_clksrc, force_areset,
        output busy, error, cur_phase
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// Steps PLL counter phases to absolute targets using per-counter phase trackers.
// Optional step timeout with sticky error flag: define PLL_PHASE_TIMEOUT_EN.
module pll_phase_stepper #(
    parameter int NCNT     = 5,
    parameter int PHASE_W  = 8,
    parameter int SCAN_DIV = 16,
    parameter int PS_HOLD  = 6,
    parameter int DONE_MIN = 8,
    parameter int TIMEOUT  = 108
) (
    input  logic                clk,
    input  logic                reset,
    pll_phase_stepper_if.slave  cmd,
    input  logic                phase_done,
    output logic                areset,
    output logic                clkswitch,
    output logic                phasestep,
    output logic                scanclk,
    output logic [2:0]          phasecounterselect,
    output logic                phaseupdown
);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int TOG_TOP = (TIMEOUT > DONE_MIN)
                           ? ((TIMEOUT > PS_HOLD) ? TIMEOUT : PS_HOLD)
                           : ((DONE_MIN > PS_HOLD) ? DONE_MIN : PS_HOLD);
    localparam int TOG_CAP = TOG_TOP + 1;
    localparam int TOG_W   = $clog2(TOG_CAP + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [TOG_W-1:0]   TOG_MAX    = TOG_W'(TOG_CAP);
    localparam logic [TOG_W-1:0]   PS_HOLD_C  = TOG_W'(PS_HOLD);
    localparam logic [TOG_W-1:0]   DONE_MIN_C = TOG_W'(DONE_MIN);
    localparam logic [2:0]         NCNT_C     = 3'(NCNT);
    localparam logic [PHASE_W-1:0] PHASE_MAX  = '1;

    typedef enum logic [2:0] {IDLE, ARESET, CLKSWITCH, PREP, STEP, DONE} state_t;

    state_t             state, next_state;
    logic [2:0]         sel_q;
    logic [PHASE_W-1:0] tgt_q;
    logic               req_src;
    logic               src_q;
    logic [2:0]         cnt;
    logic [DIV_W-1:0]   div_q;
    logic [TOG_W-1:0]   tog_q, tog_inc;
    logic [PHASE_W-1:0] tracker [NCNT];
    logic [PHASE_W-1:0] cur_trk, trk_next;
    logic               accept, tick, step_ok, timeout, at_target;

    assign accept    = (state == IDLE) && cmd.update && (cmd.sel < NCNT_C);
    assign tick      = (state == STEP) && (div_q == DIV_LAST);
    assign tog_inc   = (tog_q == TOG_MAX) ? tog_q : tog_q + 1'b1;
    assign step_ok   = tick && (tog_inc >= DONE_MIN_C) && phase_done;
    assign at_target = (cur_trk == tgt_q);

    always_comb begin
        cur_trk = '0;
        for (int i = 0; i < NCNT; i++)
            if (sel_q == 3'(i)) cur_trk = tracker[i];
    end

    always_comb begin
        cmd.cur_phase = '0;
        for (int i = 0; i < NCNT; i++)
            if (cmd.sel == 3'(i)) cmd.cur_phase = tracker[i];
    end

    // Linear stepping: the tracker saturates instead of wrapping.
    always_comb begin
        trk_next = cur_trk;
        if (phaseupdown) begin
            if (cur_trk != PHASE_MAX) trk_next = cur_trk + 1'b1;
        end else begin
            if (cur_trk != '0) trk_next = cur_trk - 1'b1;
        end
    end

`ifdef PLL_PHASE_TIMEOUT_EN
    localparam logic [TOG_W-1:0] TIMEOUT_C = TOG_W'(TIMEOUT);
    logic error_q;

    assign timeout   = tick && (tog_inc == TIMEOUT_C) && !phase_done;
    assign cmd.error = error_q;

    always_ff @(posedge clk) begin
        if (reset)        error_q <= 1'b0;
        else if (accept)  error_q <= 1'b0;
        else if (timeout) error_q <= 1'b1;
    end
`else
    assign timeout   = 1'b0;
    assign cmd.error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        areset     = 1'b0;
        clkswitch  = 1'b0;
        cmd.busy   = 1'b1;
        case (state)
            IDLE: begin
                cmd.busy = 1'b0;
                if (accept)
                    next_state = (cmd.force_areset || (cmd.pll_clksrc != src_q)) ? ARESET : PREP;
            end
            ARESET: begin
                areset = 1'b1;
                if (cnt == 3'd7) next_state = req_src ? CLKSWITCH : PREP;
            end
            CLKSWITCH: begin
                clkswitch = 1'b1;
                if (cnt == 3'd7) next_state = PREP;
            end
            PREP:    next_state = at_target ? DONE : STEP;
            STEP: begin
                if (timeout)      next_state = DONE;
                else if (step_ok) next_state = PREP;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q              <= '0;
            tgt_q              <= '0;
            req_src            <= 1'b0;
            src_q              <= 1'b0;
            cnt                <= '0;
            div_q              <= '0;
            tog_q              <= '0;
            phasestep          <= 1'b0;
            scanclk            <= 1'b0;
            phasecounterselect <= '0;
            phaseupdown        <= 1'b1;
            for (int i = 0; i < NCNT; i++) tracker[i] <= '0;
        end else begin
            cnt <= (state == ARESET || state == CLKSWITCH) ? cnt + 3'd1 : 3'd0;
            if (accept) begin
                sel_q   <= cmd.sel;
                tgt_q   <= cmd.target_phase;
                req_src <= cmd.pll_clksrc;
            end
            // The PLL phase returns to zero after areset, so every tracker follows.
            if (state == ARESET) src_q <= req_src;
            for (int i = 0; i < NCNT; i++) begin
                if (state == ARESET)                  tracker[i] <= '0;
                else if (step_ok && sel_q == 3'(i))   tracker[i] <= trk_next;
            end
            if (state == PREP) begin
                scanclk <= 1'b0;
                if (!at_target) begin
                    phasecounterselect <= sel_q + 3'd2;
                    phaseupdown        <= (tgt_q > cur_trk);
                    phasestep          <= 1'b1;
                    div_q              <= '0;
                    tog_q              <= '0;
                end
            end
            if (state == STEP) begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    scanclk <= ~scanclk;
                    tog_q   <= tog_inc;
                    if (tog_inc == PS_HOLD_C) phasestep <= 1'b0;
                end
                if (timeout) begin
                    phasestep <= 1'b0;
                    scanclk   <= 1'b0;
                end
            end
            if (state == DONE) scanclk <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: stepping, areset/clkswitch, ignored requests, timeout, reset.
module tb_pll_phase_stepper;
    localparam int PHASE_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       phase_done;
    logic       areset, clkswitch, phasestep, scanclk, phaseupdown;
    logic [2:0] pcs;

    pll_phase_stepper_if #(.PHASE_W(PHASE_W)) cmd ();

    pll_phase_stepper #(
        .NCNT(5), .PHASE_W(PHASE_W), .SCAN_DIV(16), .PS_HOLD(6), .DONE_MIN(8), .TIMEOUT(108)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd                (cmd.slave),
        .phase_done         (phase_done),
        .areset             (areset),
        .clkswitch          (clkswitch),
        .phasestep          (phasestep),
        .scanclk            (scanclk),
        .phasecounterselect (pcs),
        .phaseupdown        (phaseupdown)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0, busy_cnt = 0, ar_cnt = 0, cs_cnt = 0, ps_rise = 0, up_rise = 0;
    int scan_tog = 0, idle_scan = 0, last_ar_cyc = 0, first_cs_cyc = 0;
    logic prev_ps = 1'b0, prev_sc = 1'b0, prev_cs = 1'b0;

    // Running totals of PLL control activity; the directed steps compare deltas.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmd.busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (areset === 1'b1) begin
            ar_cnt      <= ar_cnt + 1;
            last_ar_cyc <= cyc;
        end
        if (clkswitch === 1'b1) begin
            cs_cnt <= cs_cnt + 1;
            if (!prev_cs) first_cs_cyc <= cyc;
        end
        if (phasestep === 1'b1 && !prev_ps) begin
            ps_rise <= ps_rise + 1;
            if (phaseupdown) up_rise <= up_rise + 1;
        end
        if (scanclk !== prev_sc && reset === 1'b0) scan_tog <= scan_tog + 1;
        if (cmd.busy === 1'b0 && scanclk === 1'b1) idle_scan <= idle_scan + 1;
        prev_ps <= phasestep;
        prev_sc <= scanclk;
        prev_cs <= clkswitch;
    end

    int s_busy, s_ar, s_cs, s_ps, s_up, s_tog, s_idle;

    task automatic takeSnap();
        s_busy = busy_cnt; s_ar = ar_cnt; s_cs = cs_cnt; s_ps = ps_rise;
        s_up = up_rise; s_tog = scan_tog; s_idle = idle_scan;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic [7:0] t, input logic src, input logic frc);
        cmd.sel          = s;
        cmd.target_phase = t;
        cmd.pll_clksrc   = src;
        cmd.force_areset = frc;
        cmd.update       = 1'b1;
        nextCycle();
        cmd.update       = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (cmd.busy === 1'b1 && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, " idle"}, 32'(cmd.busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " areset"},    32'(areset),      32'd0);
        checkOutput({tag, " clkswitch"}, 32'(clkswitch),   32'd0);
        checkOutput({tag, " pcs"},       32'(pcs),         32'd0);
        checkOutput({tag, " updown"},    32'(phaseupdown), 32'd1);
        checkOutput({tag, " phasestep"}, 32'(phasestep),   32'd0);
        checkOutput({tag, " scanclk"},   32'(scanclk),     32'd0);
        checkOutput({tag, " busy"},      32'(cmd.busy),    32'd0);
        checkOutput({tag, " error"},     32'(cmd.error),   32'd0);
        checkOutput({tag, " cur_phase"}, 32'(cmd.cur_phase), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; phase_done = 1'b1;
        cmd.update = 1'b0; cmd.sel = 3'd0; cmd.target_phase = '0;
        cmd.pll_clksrc = 1'b0; cmd.force_areset = 1'b0;
        repeat (3) nextCycle();
        reset = 1'b0;
        nextCycle();
        checkResetValues("reset");

        // Five up-steps on C0: 5*129+2 busy cycles.
        takeSnap();
        applyStimulus(3'd0, 8'd5, 1'b0, 1'b0);
        checkOutput("t1 busy rise", 32'(cmd.busy), 32'd1);
        waitIdle("t1", 1000);
        checkOutput("t1 busy cycles", 32'(busy_cnt - s_busy), 32'd647);
        checkOutput("t1 steps",       32'(ps_rise - s_ps),    32'd5);
        checkOutput("t1 up steps",    32'(up_rise - s_up),    32'd5);
        checkOutput("t1 scan toggles", 32'(scan_tog - s_tog), 32'd40);
        checkOutput("t1 cur_phase",   32'(cmd.cur_phase),     32'd5);
        checkOutput("t1 pcs",         32'(pcs),               32'd2);
        checkOutput("t1 updown",      32'(phaseupdown),       32'd1);
        checkOutput("t1 phasestep",   32'(phasestep),         32'd0);
        checkOutput("t1 scanclk",     32'(scanclk),           32'd0);

        // Back down to 2: three down-steps.
        takeSnap();
        applyStimulus(3'd0, 8'd2, 1'b0, 1'b0);
        waitIdle("t2", 600);
        checkOutput("t2 busy cycles", 32'(busy_cnt - s_busy), 32'd389);
        checkOutput("t2 steps",       32'(ps_rise - s_ps),    32'd3);
        checkOutput("t2 up steps",    32'(up_rise - s_up),    32'd0);
        checkOutput("t2 cur_phase",   32'(cmd.cur_phase),     32'd2);
        checkOutput("t2 updown",      32'(phaseupdown),       32'd0);
        cmd.sel = 3'd1;
        #1;
        checkOutput("t2 sel1 phase",  32'(cmd.cur_phase),     32'd0);

        // Clock source change: areset 8, clkswitch 8, then 3 up-steps on C1.
        takeSnap();
        applyStimulus(3'd1, 8'd3, 1'b1, 1'b0);
        waitIdle("t3", 800);
        checkOutput("t3 areset cycles", 32'(ar_cnt - s_ar), 32'd8);
        checkOutput("t3 clkswitch cycles", 32'(cs_cnt - s_cs), 32'd8);
        checkOutput("t3 clkswitch follows", 32'(first_cs_cyc), 32'(last_ar_cyc + 1));
        checkOutput("t3 busy cycles", 32'(busy_cnt - s_busy), 32'd405);
        checkOutput("t3 up steps",    32'(up_rise - s_up),    32'd3);
        checkOutput("t3 cur_phase",   32'(cmd.cur_phase),     32'd3);
        checkOutput("t3 pcs",         32'(pcs),               32'd3);
        cmd.sel = 3'd0;
        #1;
        checkOutput("t3 sel0 cleared", 32'(cmd.cur_phase),    32'd0);

        // Target already reached: only the 2-cycle busy pulse.
        takeSnap();
        applyStimulus(3'd1, 8'd3, 1'b1, 1'b0);
        waitIdle("t4a", 10);
        checkOutput("t4a busy cycles", 32'(busy_cnt - s_busy), 32'd2);
        checkOutput("t4a scan toggles", 32'(scan_tog - s_tog), 32'd0);
        checkOutput("t4a areset", 32'(ar_cnt - s_ar), 32'd0);

        // sel out of range is ignored even with force_areset.
        takeSnap();
        applyStimulus(3'd5, 8'd9, 1'b1, 1'b1);
        checkOutput("t4b busy", 32'(cmd.busy), 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("t4b busy cycles", 32'(busy_cnt - s_busy), 32'd0);
        checkOutput("t4b areset", 32'(ar_cnt - s_ar), 32'd0);

        // Second update while busy is dropped.
        takeSnap();
        cmd.sel = 3'd1; cmd.target_phase = 8'd3; cmd.pll_clksrc = 1'b1; cmd.force_areset = 1'b0;
        cmd.update = 1'b1;
        nextCycle();
        cmd.sel = 3'd0; cmd.target_phase = 8'd9; cmd.force_areset = 1'b1;
        nextCycle();
        cmd.update = 1'b0;
        nextCycle();
        checkOutput("t4c busy cycles", 32'(busy_cnt - s_busy), 32'd2);
        checkOutput("t4c scan toggles", 32'(scan_tog - s_tog), 32'd0);
        checkOutput("t4c areset", 32'(ar_cnt - s_ar), 32'd0);
        checkOutput("t4c sel0 phase", 32'(cmd.cur_phase), 32'd0);
        checkOutput("t4c pcs", 32'(pcs), 32'd3);
        checkOutput("t4c updown", 32'(phaseupdown), 32'd1);
        checkOutput("t4 idle scanclk", 32'(idle_scan - s_idle), 32'd0);

        // phase_done stuck low.
        phase_done = 1'b0;
        takeSnap();
        applyStimulus(3'd0, 8'd1, 1'b1, 1'b0);
`ifdef PLL_PHASE_TIMEOUT_EN
        waitIdle("t5", 2500);
        checkOutput("t5 busy cycles", 32'(busy_cnt - s_busy), 32'd1730);
        checkOutput("t5 error",       32'(cmd.error),         32'd1);
        checkOutput("t5 cur_phase",   32'(cmd.cur_phase),     32'd0);
        checkOutput("t5 phasestep",   32'(phasestep),         32'd0);
        checkOutput("t5 scanclk",     32'(scanclk),           32'd0);
        phase_done = 1'b1;
        applyStimulus(3'd0, 8'd0, 1'b1, 1'b0);
        checkOutput("t5 error cleared", 32'(cmd.error), 32'd0);
        waitIdle("t5b", 10);
`else
        repeat (2000) nextCycle();
        checkOutput("t5 still busy", 32'(cmd.busy), 32'd1);
        checkOutput("t5 error",      32'(cmd.error), 32'd0);
        checkOutput("t5 cur_phase",  32'(cmd.cur_phase), 32'd0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("t5 reset exit", 32'(cmd.busy), 32'd0);
        phase_done = 1'b1;
`endif

        // Reset in the middle of the second step (areset forced first).
        applyStimulus(3'd0, 8'd4, 1'b0, 1'b1);
        repeat (200) nextCycle();
        checkOutput("t6 busy",      32'(cmd.busy),      32'd1);
        checkOutput("t6 phasestep", 32'(phasestep),     32'd1);
        checkOutput("t6 cur_phase", 32'(cmd.cur_phase), 32'd1);
        reset = 1'b1;
        nextCycle();
        checkResetValues("t6 mid-step reset");
        reset = 1'b0;
        nextCycle();

        // One step after reset.
        takeSnap();
        applyStimulus(3'd0, 8'd1, 1'b0, 1'b0);
        waitIdle("t7", 300);
        checkOutput("t7 busy cycles", 32'(busy_cnt - s_busy), 32'd131);
        checkOutput("t7 cur_phase",   32'(cmd.cur_phase),     32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
